// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and helpers for the pooling stage.
package cnn_pkg;

    localparam int unsigned T_DEF = 20;
    localparam int unsigned L_DEF = 13;
    localparam int unsigned W_DEF = 2;

    // Position of the current sample inside its pooling window.
    typedef enum logic [1:0] {
        WIN_OPEN  = 2'd0,
        WIN_MID   = 2'd1,
        WIN_CLOSE = 2'd2
    } win_pos_e;

    function automatic int unsigned ceil_div(input int unsigned l, input int unsigned w);
        return (l + w - 1) / w;
    endfunction

endpackage

// File: rtl/pool_window_ctr.sv
// Tracks vector position p and window position k; flags window open/close.
module pool_window_ctr
    import cnn_pkg::*;
#(
    parameter int unsigned L = L_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic adv,
    output logic first,
    output logic close
);

    localparam int unsigned PW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned KW = $clog2(W);

    logic [PW-1:0] p;
    logic [KW-1:0] k;
    logic          last_p;
    win_pos_e      pos;

    assign last_p = (p == PW'(L - 1));

    always_comb begin
        pos = WIN_MID;
        if ((k == KW'(W - 1)) || last_p)
            pos = WIN_CLOSE;
        else if (k == '0)
            pos = WIN_OPEN;
    end

    // A single-sample tail window is both the first and the closing sample.
    assign first = (k == '0);
    assign close = (pos == WIN_CLOSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
            k <= '0;
        end else if (adv) begin
            p <= last_p ? '0 : p + PW'(1);
            k <= close ? '0 : k + KW'(1);
        end
    end

endmodule

// File: rtl/relu_maxpool_13_2_20.sv
// Streaming max-pool (stride = window) with optional ReLU, enabled by macro RELU_EN.
module relu_maxpool_13_2_20
    import cnn_pkg::*;
#(
    parameter int unsigned T = T_DEF,
    parameter int unsigned L = L_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready
);

    logic                accept;
    logic                first;
    logic                close;
    logic signed [T-1:0] run_max;
    logic signed [T-1:0] win_max;
    logic signed [T-1:0] y_next;

    assign x_ready = !y_valid || y_ready;
    assign accept  = x_valid && x_ready;

    pool_window_ctr #(
        .L (L),
        .W (W)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .adv   (accept),
        .first (first),
        .close (close)
    );

    always_comb begin
        win_max = x_data;
        if (!first && (run_max > x_data))
            win_max = run_max;
    end

`ifdef RELU_EN
    assign y_next = win_max[T-1] ? '0 : win_max;
`else
    assign y_next = win_max;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
        end else begin
            if (accept)
                run_max <= win_max;
            // A closing window in the transfer cycle keeps y_valid high with the new result.
            if (accept && close) begin
                y_data  <= y_next;
                y_valid <= 1'b1;
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_13_2_20.sv
// Directed self-checking bench for relu_maxpool_13_2_20 (honours RELU_EN).
module tb_relu_maxpool_13_2_20;

    localparam int T    = 20;
    localparam int NOUT = int'(cnn_pkg::ceil_div(13, 2));
`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    localparam int MINV = -(1 << 19);
    localparam int MAXV = (1 << 19) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [T-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
    logic signed [T-1:0] y_data;
    logic                y_valid;
    logic                y_ready;

    int checks = 0;
    int errors = 0;
    logic signed [T-1:0] q[$];

    relu_maxpool_13_2_20 dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, sample registered outputs, log transfers.
    task automatic step(input logic xv, input int xd, input logic yr, output logic acc);
        @(negedge clk);
        x_valid = xv;
        x_data  = xd[T-1:0];
        y_ready = yr;
        #1;
        acc = xv && x_ready;
        if (y_valid && yr)
            q.push_back(y_data);
    endtask

    task automatic send_vec(input int v[$]);
        logic acc;
        for (int i = 0; i < v.size(); i++) begin
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++)
                step(1'b1, v[i], 1'b1, acc);
            if (!acc)
                chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic drain();
        logic acc;
        repeat (4) step(1'b0, 0, 1'b1, acc);
    endtask

    task automatic cmp_q(input string tag, input int e[$]);
        int n;
        chk({tag, "_count"}, q.size(), e.size());
        n = (q.size() < e.size()) ? q.size() : e.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_%0d", tag, i), q[i], e[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        x_valid = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        q.delete();
    endtask

    initial begin
        int  v[$];
        int  e[$];
        logic acc;

        reset   = 1'b1;
        x_valid = 1'b0;
        x_data  = '0;
        y_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_x_ready", x_ready, 1);

        // Ramp vector 1..13
        q.delete();
        v = {};
        for (int i = 1; i <= 13; i++) v.push_back(i);
        send_vec(v);
        drain();
        e = {};
        for (int i = 1; i <= NOUT; i++) e.push_back((2 * i > 13) ? 13 : 2 * i);
        cmp_q("ramp", e);

        // Negative vector, element 0 = -1
        q.delete();
        v = {-1};
        for (int i = 1; i < 13; i++) v.push_back(-5);
        send_vec(v);
        drain();
        e = {};
        if (RELU) begin
            for (int i = 0; i < 7; i++) e.push_back(0);
        end else begin
            e.push_back(-1);
            for (int i = 1; i < 7; i++) e.push_back(-5);
        end
        cmp_q("neg", e);

        // Backpressure: hold y_ready low for 10 cycles after first output
        do_reset();
        step(1'b1, 1, 1'b1, acc);
        chk("bp_acc0", acc, 1);
        step(1'b1, 2, 1'b1, acc);
        chk("bp_acc1", acc, 1);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 3, 1'b0, acc);
            chk("bp_x_ready", x_ready, 0);
            chk("bp_y_valid", y_valid, 1);
            chk("bp_y_data", y_data, 2);
        end
        v = {};
        for (int i = 3; i <= 13; i++) v.push_back(i);
        send_vec(v);
        drain();
        e = {2, 4, 6, 8, 10, 12, 13};
        cmp_q("bp", e);

        // Back-to-back vectors; no window merges across the boundary
        do_reset();
        v = {};
        for (int i = 1; i <= 12; i++) v.push_back(i);
        v.push_back(50);
        v.push_back(100);
        for (int i = 2; i <= 13; i++) v.push_back(i);
        send_vec(v);
        drain();
        e = {2, 4, 6, 8, 10, 12, 50, 100, 4, 6, 8, 10, 12, 13};
        cmp_q("b2b", e);

        // Reset after a partial window holding 999
        do_reset();
        step(1'b1, 999, 1'b1, acc);
        chk("r999_acc", acc, 1);
        do_reset();
        #1;
        chk("r999_y_valid", y_valid, 0);
        chk("r999_x_ready", x_ready, 1);
        v = {};
        for (int i = 1; i <= 13; i++) v.push_back(i);
        send_vec(v);
        drain();
        e = {2, 4, 6, 8, 10, 12, 13};
        cmp_q("r999", e);

        // Full-scale extremes
        q.delete();
        v = {MINV, MAXV, MINV, MINV, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_vec(v);
        drain();
        e = {MAXV, RELU ? 0 : MINV, 0, 0, 0, 0, 0};
        cmp_q("ext", e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
